// File: rtl/exec_pkg.sv
// Shared opcodes, FSM encoding and default widths for the execute/write-back stage.
package exec_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_MUL_CYCLES = 16;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_MOV = 4'd10;
    localparam logic [3:0] OP_NOP = 4'd15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    // Single-cycle ops that produce a register write; MUL and undefined codes do not.
    function automatic logic alu_writes(input logic [3:0] op);
        return (op <= OP_SLT) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/exec_wb_unit_if.sv
// Issue bus from decode plus register-file write port and status from the unit.
interface exec_wb_unit_if
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              issue_valid;
    logic              issue_ready;
    logic [3:0]        issue_op;
    logic [ADDR_W-1:0] issue_dest;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic              zero_flag;
    logic              carry_flag;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_dest;

    modport master (
        output issue_valid, issue_op, issue_dest, op_a, op_b,
        input  issue_ready, reg_write_en, reg_write_dest, reg_write_data,
               zero_flag, carry_flag, pend_valid, pend_dest
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest, op_a, op_b,
        output issue_ready, reg_write_en, reg_write_dest, reg_write_data,
               zero_flag, carry_flag, pend_valid, pend_dest
    );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per clock, low DATA_W bits kept.
module shift_add_mul #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

    logic [DATA_W-1:0] mcand, mplier, acc, acc_nxt;
    logic [CNT_W-1:0]  cnt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // done/product are valid during the final iteration so the caller can register them on that edge
    assign done    = busy && (cnt == LAST);
    assign product = acc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end
    end
endmodule

// File: rtl/exec_wb_unit.sv
// Execute/write-back stage: single-cycle ALU, 16-cycle MUL, registered register-file write port.
module exec_wb_unit
    import exec_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES
) (
    input  logic           clk,
    input  logic           rst_n,
    exec_wb_unit_if.slave  bus
);
    typedef struct packed {
        logic [3:0]        op;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } issue_req_t;

    issue_req_t        req;
    logic [0:0]        state;
    logic              fire, mul_start, mul_busy, mul_done;
    logic [DATA_W-1:0] mul_prod;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;

    logic              wr_en_q, zero_q, carry_q;
    logic [ADDR_W-1:0] wr_dest_q, pend_dest_q;
    logic [DATA_W-1:0] wr_data_q;

    assign req       = '{op: bus.issue_op, dest: bus.issue_dest, a: bus.op_a, b: bus.op_b};
    assign fire      = bus.issue_valid && bus.issue_ready;
    assign mul_start = fire && (req.op == OP_MUL);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, req.a} + {1'b0, req.b};
        case (req.op)
            OP_ADD: {alu_c, alu_res} = sum;
            OP_SUB: begin
                alu_res = req.a - req.b;
                alu_c   = req.a < req.b;
            end
            OP_AND: alu_res = req.a & req.b;
            OP_OR:  alu_res = req.a | req.b;
            OP_XOR: alu_res = req.a ^ req.b;
            OP_NOT: alu_res = ~req.a;
            OP_SLL: alu_res = req.a << req.b[3:0];
            OP_SRL: alu_res = req.a >> req.b[3:0];
            OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(req.a) < $signed(req.b)};
            OP_MOV: alu_res = req.b;
            default: ;
        endcase
    end

    shift_add_mul #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (req.a),
        .b       (req.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wr_en_q     <= 1'b0;
            wr_dest_q   <= '0;
            wr_data_q   <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            pend_dest_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (mul_start) begin
                    state       <= ST_MUL;
                    pend_dest_q <= req.dest;
                end else if (fire && alu_writes(req.op)) begin
                    wr_en_q   <= 1'b1;
                    wr_dest_q <= req.dest;
                    wr_data_q <= alu_res;
                    zero_q    <= (alu_res == '0);
                    carry_q   <= alu_c;
                end
            end else if (mul_done) begin
                state     <= ST_IDLE;
                wr_en_q   <= 1'b1;
                wr_dest_q <= pend_dest_q;
                wr_data_q <= mul_prod;
                zero_q    <= (mul_prod == '0);
                carry_q   <= 1'b0;
            end
        end
    end

    assign bus.issue_ready    = (state == ST_IDLE);
    assign bus.reg_write_en   = wr_en_q;
    assign bus.reg_write_dest = wr_dest_q;
    assign bus.reg_write_data = wr_data_q;
    assign bus.zero_flag      = zero_q;
    assign bus.carry_flag     = carry_q;
    assign bus.pend_valid     = mul_busy;
    assign bus.pend_dest      = pend_dest_q;
endmodule

// File: tb/tb_exec_wb_unit.sv
// Directed plus randomized bench for exec_wb_unit against a transaction-level reference model.
module tb_exec_wb_unit;
    logic clk;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    exec_wb_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    exec_wb_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic        m_en, m_zero, m_carry, m_pend;
    logic [2:0]  m_dest, m_pdest;
    logic [15:0] m_data, m_mres;
    int          m_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // returns {wr, carry, data}
    function automatic logic [17:0] ref_alu(input int op, input int a, input int b);
        int sa, sb, r, wr, c;
        longint p;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        r = 0; wr = 1; c = 0;
        case (op)
            0: begin r = (a + b) % 65536; c = (a + b > 65535) ? 1 : 0; end
            1: begin r = (a - b + 65536) % 65536; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 65535 - a;
            6: r = (a * (1 << (b % 16))) % 65536;
            7: r = a / (1 << (b % 16));
            8: r = (sa < sb) ? 1 : 0;
            9: begin p = longint'(a) * longint'(b); r = int'(p % 65536); end
            10: r = b;
            default: wr = 0;
        endcase
        return {wr[0], c[0], r[15:0]};
    endfunction

    task automatic m_write(input logic [2:0] d, input logic [15:0] v, input logic c);
        m_en = 1'b1; m_dest = d; m_data = v; m_zero = (v == 16'h0); m_carry = c;
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] op,
                        input logic [2:0] d, input logic [15:0] a, input logic [15:0] b,
                        output logic acc);
        logic [17:0] r;
        rst_n = rst;
        bus.issue_valid = v; bus.issue_op = op; bus.issue_dest = d;
        bus.op_a = a; bus.op_b = b;
        @(posedge clk);
        acc = 1'b0;
        if (!rst) begin
            m_en = 0; m_dest = 0; m_data = 0; m_zero = 0; m_carry = 0;
            m_pend = 0; m_pdest = 0; m_left = 0;
        end else begin
            m_en = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_pend = 1'b0;
                    m_write(m_pdest, m_mres, 1'b0);
                end
            end else if (v) begin
                acc = 1'b1;
                r = ref_alu(int'(op), int'(a), int'(b));
                if (op == 4'd9) begin
                    m_left = 16; m_pend = 1'b1; m_pdest = d; m_mres = r[15:0];
                end else if (r[17]) begin
                    m_write(d, r[15:0], r[16]);
                end
            end
        end
        #1;
        chk("ready", bus.issue_ready, m_left == 0);
        chk("en",    bus.reg_write_en, m_en);
        chk("dest",  bus.reg_write_dest, m_dest);
        chk("data",  bus.reg_write_data, m_data);
        chk("zero",  bus.zero_flag, m_zero);
        chk("carry", bus.carry_flag, m_carry);
        chk("pend",  bus.pend_valid, m_pend);
        chk("pdest", bus.pend_dest, m_pdest);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic acc, have, rst;
        logic [3:0] op;
        logic [2:0] d;
        logic [15:0] a, b;

        step(0, 0, 0, 0, 0, 0, acc);
        step(0, 1, 0, 1, 1, 1, acc);
        step(1, 0, 0, 0, 0, 0, acc);
        chk("rst_ready", bus.issue_ready, 1'b1);
        chk("rst_en", bus.reg_write_en, 1'b0);

        // ADD wrap with carry into r3
        step(1, 1, 4'd0, 3'd3, 16'hFFFF, 16'h0001, acc);
        chk("add_data", bus.reg_write_data, 16'h0000);
        chk("add_zc", {bus.zero_flag, bus.carry_flag}, 2'b11);
        step(1, 0, 0, 0, 0, 0, acc);
        chk("add_pulse", bus.reg_write_en, 1'b0);

        // back-to-back SUB, SLT, NOP
        step(1, 1, 4'd1, 3'd1, 16'd5, 16'd7, acc);
        chk("sub_data", bus.reg_write_data, 16'hFFFE);
        chk("sub_c", bus.carry_flag, 1'b1);
        step(1, 1, 4'd8, 3'd2, 16'h8000, 16'h0001, acc);
        chk("slt_data", bus.reg_write_data, 16'h0001);
        step(1, 1, 4'd15, 3'd4, 16'h1234, 16'h5678, acc);
        chk("nop_en", bus.reg_write_en, 1'b0);

        // MUL with an ADD held upstream the whole time
        step(1, 1, 4'd9, 3'd6, 16'h0123, 16'h0045, acc);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 4'd0, 3'd5, 16'd1, 16'd2, acc);
            chk("mul_block", acc, 1'b0);
        end
        chk("mul_data", bus.reg_write_data, 16'h4E6F);
        chk("mul_dest", bus.reg_write_dest, 3'd6);
        step(1, 1, 4'd0, 3'd5, 16'd1, 16'd2, acc);
        chk("add_after_mul", acc, 1'b1);

        // MUL that wraps to 1
        step(1, 1, 4'd9, 3'd4, 16'hFFFF, 16'hFFFF, acc);
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, acc);
        chk("mulw_data", bus.reg_write_data, 16'h0001);
        chk("mulw_zc", {bus.zero_flag, bus.carry_flag}, 2'b00);

        // reset during MUL, then MOV into r0
        step(1, 1, 4'd9, 3'd7, 16'h0011, 16'h0022, acc);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, acc);
        step(0, 1, 4'd10, 3'd1, 16'h0, 16'h0055, acc);
        chk("abort", {bus.reg_write_en, bus.pend_valid, bus.issue_ready}, 3'b001);
        step(1, 1, 4'd10, 3'd0, 16'h0, 16'h00AA, acc);
        chk("mov_r0", {bus.reg_write_dest, bus.reg_write_data}, {3'd0, 16'h00AA});

        // randomized traffic; upstream holds an op until it is taken
        have = 1'b0; op = 0; d = 0; a = 0; b = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!have) begin
                have = ($urandom_range(0, 3) != 0);
                op = 4'($urandom_range(0, 15));
                d  = 3'($urandom_range(0, 7));
                a  = pick_val();
                b  = pick_val();
            end
            rst = ($urandom_range(0, 79) != 0);
            step(rst, have, op, d, a, b, acc);
            if (acc) have = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
